// File: rtl/c3_slack_pipe.sv
// c3_slack_pipe
//   Pipelined three-function logic slice: NAND2, INV and BUF applied to
//   WIDTH-bit vectors, carried through a DEPTH-stage valid/ready pipeline
//   with per-stage bubble collapse, plus a wrapping output-transfer counter.
//
// Parameters
//   WIDTH  data vector width (>=1)
//   DEPTH  number of pipeline register stages (>=1)
//   CNT_W  width of the output-transfer counter (>=1)
//
// Ports
//   tau2015_clk           clock, all flops rising-edge
//   rst                   asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   nx1, nx2              NAND operands
//   nx3                   INV operand
//   nx4                   BUF operand
//   out_valid / out_ready output handshake
//   nx12, nx33, nx44      registered ~(nx1&nx2), ~nx3, nx4 of the output beat
//   cnt_clr               synchronous clear of xfer_cnt (wins over a transfer)
//   xfer_cnt              count of completed output transfers, wrapping
//   nx_par                XOR of all bits of nx12/nx33/nx44 for the beat;
//                         present only when C3_SLACK_PIPE_PARITY_EN is defined

module c3_slack_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             tau2015_clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] nx1,
    input  logic [WIDTH-1:0] nx2,
    input  logic [WIDTH-1:0] nx3,
    input  logic [WIDTH-1:0] nx4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] nx12,
    output logic [WIDTH-1:0] nx33,
    output logic [WIDTH-1:0] nx44,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef C3_SLACK_PIPE_PARITY_EN
   ,output logic             nx_par
`endif
);

`ifdef C3_SLACK_PIPE_PARITY_EN
    localparam int PW = 3 * WIDTH + 1;
`else
    localparam int PW = 3 * WIDTH;
`endif

    logic [PW-1:0]    din;
    logic [PW-1:0]    pay [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic             full_tail;

    // Payload layout: {parity (optional), nx12, nx33, nx44}
    always_comb begin
        din = '0;
        din[3*WIDTH-1:0] = {~(nx1 & nx2), ~nx3, nx4};
`ifdef C3_SLACK_PIPE_PARITY_EN
        din[PW-1] = ^{~(nx1 & nx2), ~nx3, nx4};
`endif
    end

    // rdy[k] = !v[k] | rdy[k+1] unrolled from the output end: a stage is
    // ready when downstream accepts or any stage from k onward is empty.
    // Written as an accumulation so no signal reads its own other bits.
    always_comb begin
        full_tail = 1'b1;
        rdy       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            full_tail            = full_tail & v[DEPTH-1-i];
            rdy[DEPTH-1-i]       = out_ready | ~full_tail;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign nx12      = pay[DEPTH-1][3*WIDTH-1 -: WIDTH];
    assign nx33      = pay[DEPTH-1][2*WIDTH-1 -: WIDTH];
    assign nx44      = pay[DEPTH-1][WIDTH-1:0];
`ifdef C3_SLACK_PIPE_PARITY_EN
    assign nx_par    = pay[DEPTH-1][PW-1];
`endif

    always_ff @(posedge tau2015_clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pay[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    pay[0] <= din;
                end
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        pay[k] <= pay[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge tau2015_clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (cnt_clr) begin
            xfer_cnt <= '0;
        end else if (v[DEPTH-1] && out_ready) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_c3_slack_pipe.sv
// tb_c3_slack_pipe
//   Directed bench for c3_slack_pipe (WIDTH=4, DEPTH=3, CNT_W=2).
//   Define C3_SLACK_PIPE_PARITY_EN for both files to cover nx_par.

module tb_c3_slack_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = 2;

    logic             tau2015_clk = 1'b0;
    logic             rst         = 1'b1;
    logic             in_valid    = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] nx1 = '0;
    logic [WIDTH-1:0] nx2 = '0;
    logic [WIDTH-1:0] nx3 = '0;
    logic [WIDTH-1:0] nx4 = '0;
    logic             out_valid;
    logic             out_ready   = 1'b0;
    logic [WIDTH-1:0] nx12;
    logic [WIDTH-1:0] nx33;
    logic [WIDTH-1:0] nx44;
    logic             cnt_clr     = 1'b0;
    logic [CNT_W-1:0] xfer_cnt;
`ifdef C3_SLACK_PIPE_PARITY_EN
    logic             nx_par;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int next_in;
    int exp_id;

    c3_slack_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .tau2015_clk (tau2015_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .nx1         (nx1),
        .nx2         (nx2),
        .nx3         (nx3),
        .nx4         (nx4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .nx12        (nx12),
        .nx33        (nx33),
        .nx44        (nx44),
        .cnt_clr     (cnt_clr),
        .xfer_cnt    (xfer_cnt)
`ifdef C3_SLACK_PIPE_PARITY_EN
       ,.nx_par      (nx_par)
`endif
    );

    always #5 tau2015_clk = ~tau2015_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tau2015_clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),  0);
        chk("rst_nx12",      32'(nx12),      0);
        chk("rst_nx33",      32'(nx33),      0);
        chk("rst_nx44",      32'(nx44),      0);
        chk("rst_in_ready",  32'(in_ready),  1);
        tick();
        rst = 1'b0;

        // ---- function + latency + back-to-back throughput ----
        out_ready = 1'b1;
        in_valid  = 1'b1;
        nx1 = 4'b1100; nx2 = 4'b1010; nx3 = 4'b0110; nx4 = 4'b1001;
        tick();
        chk("fn_lat_e1", 32'(out_valid), 0);
        nx1 = 4'hF; nx2 = 4'hF; nx3 = 4'h0; nx4 = 4'h1;
        tick();
        chk("fn_lat_e2", 32'(out_valid), 0);
        in_valid = 1'b0;
        tick();
        chk("fn1_out_valid", 32'(out_valid), 1);
        chk("fn1_nx12",      32'(nx12),      32'h7);
        chk("fn1_nx33",      32'(nx33),      32'h9);
        chk("fn1_nx44",      32'(nx44),      32'h9);
`ifdef C3_SLACK_PIPE_PARITY_EN
        chk("fn1_nx_par",    32'(nx_par),    1);
`endif
        chk("fn1_cnt",       32'(xfer_cnt),  0);
        tick();
        chk("fn2_out_valid", 32'(out_valid), 1);
        chk("fn2_nx12",      32'(nx12),      32'h0);
        chk("fn2_nx33",      32'(nx33),      32'hF);
        chk("fn2_nx44",      32'(nx44),      32'h1);
`ifdef C3_SLACK_PIPE_PARITY_EN
        chk("fn2_nx_par",    32'(nx_par),    1);
`endif
        chk("fn2_cnt",       32'(xfer_cnt),  1);
        tick();
        chk("fn_drained",    32'(out_valid), 0);
        chk("fn_cnt",        32'(xfer_cnt),  2);

        // ---- backpressure: capacity DEPTH, then ordered drain ----
        out_ready = 1'b0;
        nx1 = '0; nx2 = '0; nx3 = '0;
        next_in = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            nx4 = 4'(next_in);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'(i < 3));
            if (in_ready) next_in++;
            tick();
        end
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_nx44",  32'(nx44),      1);
        chk("bp_hold_nx33",  32'(nx33),      32'hF);
        chk("bp_full",       32'(in_ready),  0);

        out_ready = 1'b1;
        exp_id = 1;
        for (int i = 0; i < 12; i++) begin
            if (next_in <= 5) begin
                in_valid = 1'b1;
                nx4 = 4'(next_in);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                chk("bp_order", 32'(nx44), 32'(exp_id));
                exp_id++;
            end
            if (in_valid && in_ready) next_in++;
            tick();
        end
        chk("bp_all_out", 32'(exp_id),   6);
        chk("bp_cnt",     32'(xfer_cnt), 3);

        // ---- reset mid-stream ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nx4 = 4'(i + 1);
            tick();
        end
        chk("mr_pre_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_cnt",       32'(xfer_cnt),  0);
        chk("mr_nx44",      32'(nx44),      0);
        chk("mr_in_ready",  32'(in_ready),  1);
        in_valid = 1'b0;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b1;
        nx4       = 4'h7;
        out_ready = 1'b1;
        tick();
        chk("mr_lat_e1", 32'(out_valid), 0);
        in_valid = 1'b0;
        tick();
        chk("mr_lat_e2", 32'(out_valid), 0);
        tick();
        chk("mr_lat_e3", 32'(out_valid), 1);
        chk("mr_nx44_7", 32'(nx44),      7);
        tick();
        chk("mr_drained", 32'(out_valid), 0);
        chk("mr_cnt1",    32'(xfer_cnt),  1);

        // ---- bubble collapse under stall ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nx4       = 4'hA;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        nx4      = 4'hB;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_valid",    32'(out_valid), 1);
        chk("bub_nx44_a",   32'(nx44),      32'hA);
        chk("bub_in_ready", 32'(in_ready),  1);
        tick();
        chk("bub_hold_a",   32'(nx44),      32'hA);
        out_ready = 1'b1;
        tick();
        chk("bub_b_valid",  32'(out_valid), 1);
        chk("bub_b_nx44",   32'(nx44),      32'hB);
        tick();
        chk("bub_empty",    32'(out_valid), 0);
        chk("bub_cnt",      32'(xfer_cnt),  3);

        // ---- counter clear and wrap ----
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_idle", 32'(xfer_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5);
            nx4 = 4'(i);
            tick();
        end
        chk("wrap_cnt",   32'(xfer_cnt),  1);
        chk("wrap_empty", 32'(out_valid), 0);

        in_valid = 1'b1;
        nx4      = 4'h3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("clrx_valid", 32'(out_valid), 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clrx_cnt",   32'(xfer_cnt),  0);
        chk("clrx_gone",  32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
